// File: rtl/seq_alu_pipe.sv
// Pipelined ALU: eight operations including a running accumulator, with a
// valid/ready handshake and STAGES delay registers stalled globally on backpressure.
module seq_alu_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [2:0]       op,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_ACC = 3'd5,
    OP_MIN = 3'd6,
    OP_MAX = 3'd7
  } op_e;

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   acc_w;
  logic [WIDTH-1:0] calc_result;
  logic             calc_carry;

  logic             st_valid  [STAGES];
  logic [WIDTH-1:0] st_result [STAGES];
  logic             st_carry  [STAGES];
  logic             st_zero   [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // A same-cycle clear is folded in ahead of the add, so ACC+clear yields a.
  assign acc_base = acc_clear ? '0 : acc;
  assign add_w    = {1'b0, operand_a} + {1'b0, operand_b};
  assign sub_w    = {1'b0, operand_a} - {1'b0, operand_b};
  assign acc_w    = {1'b0, acc_base} + {1'b0, operand_a};

  always_comb begin
    calc_result = '0;
    calc_carry  = 1'b0;
    case (op_e'(op))
      OP_ADD: {calc_carry, calc_result} = add_w;
      OP_SUB: {calc_carry, calc_result} = sub_w;
      OP_AND: calc_result = operand_a & operand_b;
      OP_OR:  calc_result = operand_a | operand_b;
      OP_XOR: calc_result = operand_a ^ operand_b;
      OP_ACC: {calc_carry, calc_result} = acc_w;
      OP_MIN: calc_result = (operand_a < operand_b) ? operand_a : operand_b;
      OP_MAX: calc_result = (operand_a > operand_b) ? operand_a : operand_b;
      default: begin
        calc_result = '0;
        calc_carry  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (accept && op_e'(op) == OP_ACC) begin
      acc <= acc_w[WIDTH-1:0];
    end else if (acc_clear) begin
      acc <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        st_valid[i]  <= 1'b0;
        st_result[i] <= '0;
        st_carry[i]  <= 1'b0;
        st_zero[i]   <= 1'b0;
      end
    end else if (advance) begin
      st_valid[0]  <= accept;
      st_result[0] <= calc_result;
      st_carry[0]  <= calc_carry;
      st_zero[0]   <= (calc_result == '0);
      for (int unsigned i = 1; i < STAGES; i++) begin
        st_valid[i]  <= st_valid[i-1];
        st_result[i] <= st_result[i-1];
        st_carry[i]  <= st_carry[i-1];
        st_zero[i]   <= st_zero[i-1];
      end
    end
  end

  assign out_valid = st_valid[STAGES-1];
  assign result    = st_result[STAGES-1];
  assign carry     = st_carry[STAGES-1];
  assign zero      = st_zero[STAGES-1];

endmodule

// File: tb/tb_seq_alu_pipe.sv
// Directed bench for seq_alu_pipe (WIDTH=4, STAGES=2): vector table plus
// hand-written backpressure and mid-stream reset sequences.
module tb_seq_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] operand_a;
  logic [3:0] operand_b;
  logic [2:0] op;
  logic       acc_clear;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       carry;
  logic       zero;

  int tests = 0;
  int fails = 0;

  seq_alu_pipe #(.WIDTH(4), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .op(op), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       clr;
    logic [3:0] exp_r;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: accept, then result one cycle after the accept edge.
  task automatic run_txn(input vec_t v);
    op = v.op; operand_a = v.a; operand_b = v.b; acc_clear = v.clr;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({v.name, ".in_ready"}, int'(in_ready), 1);
    step();
    in_valid = 1'b0; acc_clear = 1'b0;
    chk({v.name, ".early_valid"}, int'(out_valid), 0);
    step();
    chk({v.name, ".out_valid"}, int'(out_valid), 1);
    chk({v.name, ".result"}, int'(result), int'(v.exp_r));
    chk({v.name, ".carry"}, int'(carry), int'(v.exp_c));
    chk({v.name, ".zero"}, int'(zero), int'(v.exp_z));
    step();
  endtask

  vec_t vecs[$];
  vec_t v;
  int   got[$];
  int   idx;

  initial begin
    rst = 1'b1; in_valid = 1'b0; operand_a = '0; operand_b = '0; op = '0;
    acc_clear = 1'b0; out_ready = 1'b1;

    //        name       op    a      b      clr   r      c     z
    vecs.push_back('{"add9_8",  3'd0, 4'd9,  4'd8,  1'b0, 4'd1,  1'b1, 1'b0});
    vecs.push_back('{"add15_1", 3'd0, 4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b1});
    vecs.push_back('{"sub3_5",  3'd1, 4'd3,  4'd5,  1'b0, 4'd14, 1'b1, 1'b0});
    vecs.push_back('{"sub5_5",  3'd1, 4'd5,  4'd5,  1'b0, 4'd0,  1'b0, 1'b1});
    vecs.push_back('{"and",     3'd2, 4'd12, 4'd10, 1'b0, 4'd8,  1'b0, 1'b0});
    vecs.push_back('{"or",      3'd3, 4'd12, 4'd10, 1'b0, 4'd14, 1'b0, 1'b0});
    vecs.push_back('{"xor",     3'd4, 4'd12, 4'd10, 1'b0, 4'd6,  1'b0, 1'b0});
    vecs.push_back('{"and_z",   3'd2, 4'd5,  4'd10, 1'b0, 4'd0,  1'b0, 1'b1});
    vecs.push_back('{"min",     3'd6, 4'd2,  4'd12, 1'b0, 4'd2,  1'b0, 1'b0});
    vecs.push_back('{"max",     3'd7, 4'd2,  4'd12, 1'b0, 4'd12, 1'b0, 1'b0});
    vecs.push_back('{"acc7a",   3'd5, 4'd7,  4'd3,  1'b0, 4'd7,  1'b0, 1'b0});
    vecs.push_back('{"acc7b",   3'd5, 4'd7,  4'd9,  1'b0, 4'd14, 1'b0, 1'b0});
    vecs.push_back('{"acc7c",   3'd5, 4'd7,  4'd0,  1'b0, 4'd5,  1'b1, 1'b0});
    vecs.push_back('{"acc3clr", 3'd5, 4'd3,  4'd0,  1'b1, 4'd3,  1'b0, 1'b0});
    vecs.push_back('{"xorclr",  3'd4, 4'd3,  4'd3,  1'b1, 4'd0,  1'b0, 1'b1});
    vecs.push_back('{"acc2",    3'd5, 4'd2,  4'd15, 1'b0, 4'd2,  1'b0, 1'b0});

    step(); step();
    rst = 1'b0;
    #1;
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.result", int'(result), 0);
    chk("rst.carry", int'(carry), 0);
    chk("rst.zero", int'(zero), 0);
    chk("rst.in_ready", int'(in_ready), 1);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Backpressure: four ADDs, consumer stalls for 3 cycles once the first result is up.
    idx = 0;
    op = 3'd0; acc_clear = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in_valid  = (idx < 4);
      operand_a = 4'(idx + 1);
      operand_b = 4'(idx + 1);
      out_ready = !(k >= 2 && k <= 4);
      #1;
      if (k >= 2 && k <= 4) begin
        chk("bp.stall_in_ready", int'(in_ready), 0);
        chk("bp.stall_valid", int'(out_valid), 1);
        chk("bp.stall_result", int'(result), 2);
      end
      if (out_valid && out_ready) got.push_back(int'(result));
      if (in_valid && in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    chk("bp.count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp.order%0d", i), (i < got.size()) ? got[i] : -1, 2 * (i + 1));

    // Reset mid-stream with acc=9 and two transactions in flight.
    v = '{"acc9", 3'd5, 4'd9, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0};
    run_txn(v);
    out_ready = 1'b1; op = 3'd0; in_valid = 1'b1;
    operand_a = 4'd1; operand_b = 4'd1; step();
    operand_a = 4'd2; operand_b = 4'd2; step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mrst.out_valid", int'(out_valid), 0);
    chk("mrst.result", int'(result), 0);
    chk("mrst.in_ready", int'(in_ready), 1);
    step();
    chk("mrst.drained", int'(out_valid), 0);
    v = '{"acc1", 3'd5, 4'd1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0};
    run_txn(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_alu_pipe.md
# seq_alu_pipe

Parametrised, pipelined successor to the 4-bit sequential operand/result element. Takes two WIDTH-bit operands plus a 3-bit opcode per transaction through a valid/ready handshake, computes one of eight operations (including a running accumulator), and delivers the result with carry and zero flags after a configurable number of register stages. It sits between an operand source (bench stimulus or upstream control) and any result consumer able to apply backpressure.

## Interface
- WIDTH, 4: operand, result and accumulator width (≥2).
- STAGES, 2: pipeline depth in cycles, legal range 1..4.

- clk  input  1  Single clock; everything samples on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- in_valid  input  1  Operand transaction present.
- in_ready  output  1  Block accepts the transaction this cycle.
- operand_a  input  WIDTH  First operand, unsigned.
- operand_b  input  WIDTH  Second operand, unsigned.
- op  input  3  Operation select.
- acc_clear  input  1  Synchronous accumulator clear.
- out_valid  output  1  Result present at the output.
- out_ready  input  1  Consumer takes the result this cycle.
- result  output  WIDTH  Operation result.
- carry  output  1  Carry or borrow flag for the result.
- zero  output  1  High when result == 0.

## Operation
- Opcodes:
  - 0 ADD: a+b, carry = carry-out.
  - 1 SUB: a−b mod 2^WIDTH, carry = borrow (a<b).
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 ACC: acc ← acc+a, result = new acc, carry = carry-out of that add.
  - 6 MIN (unsigned).
  - 7 MAX (unsigned).
- carry = 0 for opcodes 2, 3, 4, 6 and 7. zero is always computed from the result.
- Transaction accepted when in_valid && in_ready.
- Accumulator:
  - Internal WIDTH-bit register, updated only on an accepted ACC transaction. Wraps mod 2^WIDTH.
  - acc_clear high sets acc to 0 at the next edge.
  - acc_clear in the same cycle as an accepted ACC: the clear applies first, so acc ← a and the result is a with carry 0.
  - operand_b is ignored for ACC.
- Pipeline:
  - STAGES registers, each holding {valid, result, carry, zero}.
  - Computation is done combinationally before stage 1. The later stages are delay only.
  - Global stall: the pipeline advances when advance = !out_valid || out_ready.
  - in_ready = advance, combinational, with no dependency on in_valid.
  - Bubbles are not compressed. When the pipeline advances without an accepted input, a 0-valid entry enters stage 1.
  - Order is strictly preserved. No transaction is dropped or duplicated.
- Outputs come directly from the last stage register.
- Reset: every stage valid ← 0, result/carry/zero ← 0, acc ← 0.
  - Outputs after reset: out_valid = 0, result = 0, carry = 0, zero = 0, in_ready = 1.
  - rst has priority over all other inputs.
- Reset mid-operation: all in-flight transactions are discarded and acc is zeroed. The next edge after rst deasserts behaves as a fresh start.

## Timing
- Latency: a transaction accepted at edge N appears with out_valid = 1 after edge N+STAGES−1. For STAGES=1 it is visible in the cycle following acceptance.
- Throughput: one transaction per cycle while out_ready = 1.
- While out_valid && !out_ready:
  - All stages hold, and in_ready = 0.
  - result, carry and zero stay stable until the consumer takes them.
- ACC results are accumulator values in acceptance order; back-to-back ACC ops chain with no hazard.
- acc_clear takes effect regardless of stall. A non-ACC op accepted together with acc_clear executes normally, and acc still clears.

## Test plan
All scenarios use WIDTH=4, STAGES=2.
- ADD with a=9, b=8, out_ready=1 -> result=1, carry=1, zero=0, out_valid one cycle after the accept edge.
- SUB with a=3, b=5 -> result=14, carry=1. SUB with a=5, b=5 -> result=0, zero=1, carry=0.
- ACC with a=7 three times -> results 7, 14, 5 (carry=1 on the third). Then ACC a=3 together with acc_clear -> result 3, carry 0.
- Logic and compare with a=4'b1100, b=4'b1010 -> AND=8, OR=14, XOR=6. MIN with a=2, b=12 -> 2. MAX with a=2, b=12 -> 12.
- Backpressure: stream four ADDs (1+1, 2+2, 3+3, 4+4), with out_ready low for 3 cycles after the first result -> in_ready=0 during the stall, result held at 2, then 2, 4, 6, 8 in order with no loss.
- Reset mid-stream: two transactions in flight plus acc=9, assert rst for one cycle -> out_valid=0, result=0, in_ready=1. A following ACC with a=1 -> result 1.
